seven_segment: RTL and testbench
================================

Name: seven_segment

Overview:
- Registered 4-bit code to 7-segment glyph decoder for the board's multiplexed 8-digit display.
- Instantiated once inside the display scanner. The scanner time-multiplexes the digit code onto in4 and drives the digit enables itself.
- Digit enables and segments are active-low (common-anode).
- Code 4'hF is the scanner's "value out of range" marker and renders as a dash.

Parameters:
- ACTIVE_LOW, 1, 1: a lit segment drives 0. 0: a lit segment drives 1 (whole output vector inverted).
- HEX_EN, 1, 1: codes 10-14 render hex glyphs A,b,C,d,E. 0: codes 10-14 render blank.

Ports:
- Clk, input, 1: system clock (100 MHz), rising-edge.
- Rst_n, input, 1: reset. One clock; reset is asynchronous and active-low.
- in4, input, 4: digit code to display.
- out7, output, 7: segment drive, out7[6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.

Behaviour:
- out7 is a register. On each rising Clk, out7 loads the glyph for the current in4. Latency is 1 cycle; no handshake.
- Rst_n low forces out7 to the blank pattern immediately (asynchronous): 7'b1111111 when ACTIVE_LOW=1, 7'b0000000 when ACTIVE_LOW=0.
- On release, decoding resumes at the first rising edge.
- Glyph table, active-high logical form, bit order abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - A(10)=1110111, b(11)=0011111, C(12)=1001110, d(13)=0111101, E(14)=1001111
  - 15=dash 0000001
  - blank=0000000
- Physical out7 = logical pattern XOR {7{ACTIVE_LOW}}.
- HEX_EN=0: codes 10-14 produce blank. Code 15 still produces the dash.
- X/Z on in4 is not required to be handled beyond producing a defined register value. The case statement carries a default to blank.
- A change of in4 between edges is ignored; only the value sampled at the edge matters.
- There is no decimal-point output. DP is tied off by the parent.

Decomposition:
- Shared display package holds:
  - SEG_* glyph constants (7-bit, active-high logical form)
  - CODE_DASH = 4'hF
  - SEG_BLANK
- The scanner (Two4DigitDisplay-class modules) and this block both import it.
- Decoder is a pure combinational function (seg_glyph) in the package, plus the output register here.
- No further sub-module.

Test Plan:
- Reset: hold Rst_n=0 with in4=4'd8, toggling Clk -> out7=7'b1111111 throughout. Assert Rst_n low mid-cycle after displaying 8 -> out7 goes to 7'b1111111 without waiting for a clock edge.
- Decimal sweep, ACTIVE_LOW=1: in4=0..9, one per cycle -> out7 one cycle later equals 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- Hex and overflow, HEX_EN=1, ACTIVE_LOW=1: in4=10..15 -> 0001000, 1100000, 0110001, 1000010, 0110000, 1111110.
- HEX_EN=0: in4=10..14 -> 1111111 each. in4=15 -> 1111110.
- ACTIVE_LOW=0: in4=8 -> 1111111. in4=1 -> 0110000. Reset -> 0000000.
- Latency and sampling: change in4 3->7 midway between edges -> out7 holds the 3 glyph until the next rising edge, then shows 0001111.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared display definitions: active-high glyph constants and the code-to-glyph decoder.
// Imported by the digit scanners and by the registered segment decoder.
package seven_segment_pkg;

  localparam logic [3:0] CODE_DASH = 4'hF;

  // Bit order abcdefg, a lit segment is 1.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_glyph(input logic [3:0] code, input logic hexEn);
    logic [6:0] glyph;
    glyph = SEG_BLANK;
    case (code)
      4'd0:      glyph = SEG_0;
      4'd1:      glyph = SEG_1;
      4'd2:      glyph = SEG_2;
      4'd3:      glyph = SEG_3;
      4'd4:      glyph = SEG_4;
      4'd5:      glyph = SEG_5;
      4'd6:      glyph = SEG_6;
      4'd7:      glyph = SEG_7;
      4'd8:      glyph = SEG_8;
      4'd9:      glyph = SEG_9;
      4'd10:     glyph = hexEn ? SEG_A : SEG_BLANK;
      4'd11:     glyph = hexEn ? SEG_B : SEG_BLANK;
      4'd12:     glyph = hexEn ? SEG_C : SEG_BLANK;
      4'd13:     glyph = hexEn ? SEG_D : SEG_BLANK;
      4'd14:     glyph = hexEn ? SEG_E : SEG_BLANK;
      CODE_DASH: glyph = SEG_DASH;
      default:   glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seven_segment.sv
// Registered 4-bit code to 7-segment decoder; out7 is valid 1 cycle after in4 is sampled.
// No backpressure: a new code is accepted on every rising edge.
module seven_segment
  import seven_segment_pkg::*;
#(
  parameter logic ACTIVE_LOW = 1'b1,
  parameter logic HEX_EN     = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] in4,
  output logic [6:0] out7
);

  // Common-anode boards invert the whole logical pattern, including blank.
  localparam logic [6:0] POLARITY = {7{ACTIVE_LOW}};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out7 <= SEG_BLANK ^ POLARITY;
    end else begin
      out7 <= seg_glyph(in4, HEX_EN) ^ POLARITY;
    end
  end

endmodule

// File: tb/tb_seven_segment.sv
// Directed checks of the registered segment decoder in three parameter builds.
module tb_seven_segment;

  logic       Clk;
  logic       Rst_n;
  logic [3:0] in4;
  logic [6:0] outDef;   // ACTIVE_LOW=1, HEX_EN=1
  logic [6:0] outNoHex; // ACTIVE_LOW=1, HEX_EN=0
  logic [6:0] outHigh;  // ACTIVE_LOW=0, HEX_EN=1

  int total = 0;
  int bad   = 0;

  seven_segment #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) dutDef (
    .Clk(Clk), .Rst_n(Rst_n), .in4(in4), .out7(outDef)
  );
  seven_segment #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) dutNoHex (
    .Clk(Clk), .Rst_n(Rst_n), .in4(in4), .out7(outNoHex)
  );
  seven_segment #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) dutHigh (
    .Clk(Clk), .Rst_n(Rst_n), .in4(in4), .out7(outHigh)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive a code on the falling edge, then sample just after the rising edge that captures it.
  task automatic apply(input logic [3:0] code);
    @(negedge Clk);
    in4 = code;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [6:0] expDec [10];
    logic [6:0] expHex [6];
    logic [6:0] expNoHex [6];

    expDec   = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    expHex   = '{7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b1111110};
    expNoHex = '{7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111110};

    // Reset held across clock edges with a lit code on the input.
    Rst_n = 1'b0;
    in4   = 4'd8;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("rst_hold_def_%0d", i), outDef, 7'b1111111);
      chk($sformatf("rst_hold_nohex_%0d", i), outNoHex, 7'b1111111);
      chk($sformatf("rst_hold_high_%0d", i), outHigh, 7'b0000000);
    end

    @(negedge Clk);
    Rst_n = 1'b1;
    apply(4'd8);
    chk("show8_def", outDef, 7'b0000000);
    chk("show8_high", outHigh, 7'b1111111);

    // Asynchronous reset between edges.
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_rst_def", outDef, 7'b1111111);
    chk("async_rst_high", outHigh, 7'b0000000);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply(4'(i));
      chk($sformatf("dec_def_%0d", i), outDef, expDec[i]);
      chk($sformatf("dec_nohex_%0d", i), outNoHex, expDec[i]);
    end

    for (int i = 0; i < 6; i++) begin
      apply(4'(10 + i));
      chk($sformatf("hex_def_%0d", 10 + i), outDef, expHex[i]);
      chk($sformatf("hex_nohex_%0d", 10 + i), outNoHex, expNoHex[i]);
    end

    apply(4'd1);
    chk("high_1", outHigh, 7'b0110000);
    apply(4'd15);
    chk("high_dash", outHigh, 7'b0000001);

    // Input changes between edges must not reach the output early.
    apply(4'd3);
    chk("lat_hold3_a", outDef, 7'b0000110);
    @(negedge Clk);
    in4 = 4'd7;
    #1;
    chk("lat_hold3_b", outDef, 7'b0000110);
    @(posedge Clk);
    #1;
    chk("lat_show7", outDef, 7'b0001111);

    // A glitch that settles before the edge: only the sampled value counts.
    #2;
    in4 = 4'd2;
    #2;
    in4 = 4'd5;
    chk("glitch_hold7", outDef, 7'b0001111);
    @(posedge Clk);
    #1;
    chk("glitch_show5", outDef, 7'b0100100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
